// File: rtl/cmos_upload_ctl.sv
// HPS upload reader: pauses the williams2 CPU and streams the 4-bit CMOS RAM out as {4'hF, nibble} bytes.
// Optional CMOS_CHECKSUM_EN: a read one past the image returns the mod-256 sum of the nibbles served.
module cmos_upload_ctl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned UP_INDEX = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned PAUSE_TO = 4095
) (
  input  logic              clock_12,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              cpu_pause,
  input  logic              cpu_halted,
  output logic [ADDR_W-1:0] cmos_addr,
  output logic              cmos_rd,
  input  logic [3:0]        cmos_q,
  output logic              upload_active,
  output logic              upload_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PC_W  = (PAUSE_TO < 2) ? 1 : $clog2(PAUSE_TO + 1);
  localparam logic [24:0] DEPTH_A = 25'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE_REQ, S_READY, S_FETCH, S_PRESENT, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic              sel, sel_q;
  logic [PC_W-1:0]   pause_cnt_q, pause_cnt_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              bypass_q, bypass_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        din_d;
  logic              wait_d, pause_d, rd_d, active_d, done_d;
  logic [ADDR_W-1:0] addr_d;
`ifdef CMOS_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  assign sel = ioctl_upload && (ioctl_index == 16'(UP_INDEX));

  // Next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    bypass_d    = bypass_q;
    data_d      = data_q;
    din_d       = ioctl_din;
    wait_d      = ioctl_wait;
    pause_d     = cpu_pause;
    addr_d      = cmos_addr;
    rd_d        = 1'b0;
    active_d    = upload_active;
    done_d      = 1'b0;
`ifdef CMOS_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (state_q != S_IDLE && state_q != S_FINISH && !sel) begin
      // Upload withdrawn (or index changed): abandon any fetch in flight
      state_d = S_FINISH;
      pause_d = 1'b0;
      wait_d  = 1'b0;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel && !sel_q) begin
            state_d     = S_PAUSE_REQ;
            pause_d     = 1'b1;
            wait_d      = 1'b1;
            active_d    = 1'b1;
            pause_cnt_d = '0;
`ifdef CMOS_CHECKSUM_EN
            sum_d       = '0;
`endif
          end
        end
        S_PAUSE_REQ: begin
          if (cpu_halted || pause_cnt_q == PC_W'(PAUSE_TO)) begin
            state_d = S_READY;
            wait_d  = 1'b0;
          end else begin
            pause_cnt_d = pause_cnt_q + PC_W'(1);
          end
        end
        S_READY: begin
          if (ioctl_rd) begin
            wait_d    = 1'b1;
            lat_cnt_d = '0;
            state_d   = S_FETCH;
            if (ioctl_addr < DEPTH_A) begin
              addr_d   = ioctl_addr[ADDR_W-1:0];
              rd_d     = 1'b1;
              bypass_d = 1'b0;
            end else begin
              // Out-of-image reads never touch the RAM; one slot keeps a fixed turnaround
              bypass_d = 1'b1;
              data_d   = 8'hFF;
`ifdef CMOS_CHECKSUM_EN
              if (ioctl_addr == DEPTH_A) data_d = sum_q;
`endif
            end
          end
        end
        S_FETCH: begin
          if (bypass_q) begin
            state_d = S_PRESENT;
          end else if (lat_cnt_q == 2'(RD_LAT)) begin
            data_d  = {4'hF, cmos_q};
`ifdef CMOS_CHECKSUM_EN
            sum_d   = sum_q + {4'h0, cmos_q};
`endif
            state_d = S_PRESENT;
          end else begin
            lat_cnt_d = lat_cnt_q + 2'd1;
          end
        end
        S_PRESENT: begin
          din_d   = data_q;
          wait_d  = 1'b0;
          state_d = S_READY;
        end
        S_FINISH: begin
          active_d = 1'b0;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sel_q         <= 1'b0;
      pause_cnt_q   <= '0;
      lat_cnt_q     <= '0;
      bypass_q      <= 1'b0;
      data_q        <= 8'hFF;
      ioctl_din     <= 8'hFF;
      ioctl_wait    <= 1'b0;
      cpu_pause     <= 1'b0;
      cmos_addr     <= '0;
      cmos_rd       <= 1'b0;
      upload_active <= 1'b0;
      upload_done   <= 1'b0;
`ifdef CMOS_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel;
      pause_cnt_q   <= pause_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      bypass_q      <= bypass_d;
      data_q        <= data_d;
      ioctl_din     <= din_d;
      ioctl_wait    <= wait_d;
      cpu_pause     <= pause_d;
      cmos_addr     <= addr_d;
      cmos_rd       <= rd_d;
      upload_active <= active_d;
      upload_done   <= done_d;
`ifdef CMOS_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmos_upload_ctl.sv
// Scoreboard bench for cmos_upload_ctl: reads are queued with expected byte and turnaround, a monitor checks them.
module tb_cmos_upload_ctl;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned UP_INDEX = 4;
  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned PAUSE_TO = 15;

  logic              clock_12 = 1'b0;
  logic              reset;
  logic              ioctl_upload;
  logic [15:0]       ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              cpu_pause;
  logic              cpu_halted;
  logic [ADDR_W-1:0] cmos_addr;
  logic              cmos_rd;
  logic [3:0]        cmos_q;
  logic              upload_active;
  logic              upload_done;
  logic              halt_auto;

  typedef struct {
    int         addr;
    logic [7:0] din;
    int         lat;
    int         issue;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mem [0:1023];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         rd_cnt = 0;
  logic       wait_prev = 1'b0;
  logic [7:0] sum_m = 8'h00;

  cmos_upload_ctl #(
    .ADDR_W(ADDR_W), .UP_INDEX(UP_INDEX), .RD_LAT(RD_LAT), .PAUSE_TO(PAUSE_TO)
  ) dut (
    .clock_12(clock_12), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .cpu_pause(cpu_pause), .cpu_halted(cpu_halted),
    .cmos_addr(cmos_addr), .cmos_rd(cmos_rd), .cmos_q(cmos_q),
    .upload_active(upload_active), .upload_done(upload_done)
  );

  always #5 clock_12 = ~clock_12;
  always @(posedge clock_12) cyc <= cyc + 1;

  // One-cycle-latency CMOS RAM and a CPU that acknowledges the pause immediately when enabled
  always @(posedge clock_12) if (cmos_rd) cmos_q <= mem[cmos_addr];
  assign cpu_halted = halt_auto & cpu_pause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int a);
    if (a < 1024) return {4'hF, mem[a[9:0]]};
`ifdef CMOS_CHECKSUM_EN
    if (a == 1024) return sum_m;
`endif
    return 8'hFF;
  endfunction

  // Monitor: each fall of ioctl_wait with a read outstanding completes the oldest read
  always @(negedge clock_12) begin
    exp_t e;
    if (upload_done) done_cnt++;
    if (cmos_rd) rd_cnt++;
    if (wait_prev && !ioctl_wait && sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("din@%0d", e.addr), 32'(ioctl_din), 32'(e.din));
      chk($sformatf("lat@%0d", e.addr), 32'(cyc - e.issue - 1), 32'(e.lat));
    end
    wait_prev = ioctl_wait;
  end

  task automatic do_read(input int a);
    exp_t e;
    int   n;
    @(negedge clock_12);
    e.addr  = a;
    e.din   = exp_byte(a);
    e.lat   = (a < 1024) ? int'(RD_LAT) + 2 : 2;
    e.issue = cyc;
    sb.push_back(e);
    if (a < 1024) sum_m = sum_m + 8'(mem[a[9:0]]);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'(a);
    @(negedge clock_12);
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      @(negedge clock_12);
      n++;
    end
    chk($sformatf("rd_done@%0d", a), 32'(ioctl_wait), 32'd0);
  endtask

  task automatic start_upload(input logic halt, output int lat);
    int c;
    int n;
    @(negedge clock_12);
    halt_auto    = halt;
    ioctl_index  = 16'(UP_INDEX);
    ioctl_upload = 1'b1;
    sum_m        = 8'h00;
    c = cyc;
    n = 0;
    do begin
      @(negedge clock_12);
      n++;
    end while ((ioctl_wait || !upload_active) && n < 100);
    lat = cyc - c - 1;
    chk("ready_reached", 32'(upload_active && !ioctl_wait), 32'd1);
  endtask

  task automatic end_upload();
    int d0;
    d0 = done_cnt;
    @(negedge clock_12);
    ioctl_upload = 1'b0;
    repeat (3) @(negedge clock_12);
    chk("done_pulse", 32'(done_cnt - d0), 32'd1);
    chk("end_pause", 32'(cpu_pause), 32'd0);
    chk("end_active", 32'(upload_active), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   d0;
    int   r0;
    logic seen;
    logic din_ok;

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 16'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0; halt_auto = 1'b0; cmos_q = 4'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 4'(i);
    repeat (3) @(negedge clock_12);
    chk("rst_din", 32'(ioctl_din), 32'hFF);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_pause", 32'(cpu_pause), 32'd0);
    chk("rst_active", 32'(upload_active), 32'd0);
    chk("rst_done", 32'(upload_done), 32'd0);
    chk("rst_cmos_rd", 32'(cmos_rd), 32'd0);
    reset = 1'b0;

    // Wrong index: block must stay idle and ignore reads
    @(negedge clock_12);
    ioctl_index = 16'd3; ioctl_upload = 1'b1;
    seen = 1'b0; din_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_12);
      ioctl_rd = (i == 5); ioctl_addr = 25'd2;
      seen   = seen | cpu_pause | ioctl_wait | upload_active;
      din_ok = din_ok & (ioctl_din == 8'hFF);
    end
    chk("idx3_idle", 32'(seen), 32'd0);
    chk("idx3_din", 32'(din_ok), 32'd1);
    ioctl_upload = 1'b0; ioctl_rd = 1'b0;

    // Halt never acknowledged: READY after PAUSE_TO+1 cycles, pause held throughout
    start_upload(1'b0, lat);
    chk("pause_timeout", 32'(lat), 32'(PAUSE_TO + 1));
    chk("pause_held", 32'(cpu_pause), 32'd1);
    r0 = rd_cnt;
    do_read(1500);
    do_read(1029);
    do_read(1024);
    do_read(33554431);
    chk("oor_no_cmos_rd", 32'(rd_cnt - r0), 32'd0);
    do_read(3);
    chk("pause_still", 32'(cpu_pause), 32'd1);
    end_upload();

    // Full image sweep with a responsive CPU
    start_upload(1'b1, lat);
    for (int a = 0; a < 1024; a++) do_read(a);
    do_read(1024);
    repeat (5) @(negedge clock_12);
    chk("din_hold", 32'(ioctl_din), 32'(exp_byte(1024)));
    end_upload();

    // Reset in the middle of a fetch drops the pause asynchronously
    start_upload(1'b1, lat);
    @(negedge clock_12);
    ioctl_rd = 1'b1; ioctl_addr = 25'd7;
    @(negedge clock_12);
    ioctl_rd = 1'b0;
    chk("fetch_wait", 32'(ioctl_wait), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_pause", 32'(cpu_pause), 32'd0);
    chk("arst_wait", 32'(ioctl_wait), 32'd0);
    chk("arst_active", 32'(upload_active), 32'd0);
    ioctl_upload = 1'b0;
    @(negedge clock_12);
    @(negedge clock_12);
    reset = 1'b0;

    // Uniform image, checksum slot, then index change ends the upload
    for (int i = 0; i < 1024; i++) mem[i] = 4'h5;
    start_upload(1'b1, lat);
    for (int a = 0; a < 1024; a++) do_read(a);
    do_read(1024);
`ifdef CMOS_CHECKSUM_EN
    chk("sum_slot", 32'(ioctl_din), 32'h00);
`else
    chk("sum_slot", 32'(ioctl_din), 32'hFF);
`endif
    d0 = done_cnt;
    @(negedge clock_12);
    ioctl_index = 16'd3;
    repeat (3) @(negedge clock_12);
    chk("idxchg_done", 32'(done_cnt - d0), 32'd1);
    chk("idxchg_pause", 32'(cpu_pause), 32'd0);
    chk("idxchg_wait", 32'(ioctl_wait), 32'd0);
    chk("idxchg_active", 32'(upload_active), 32'd0);
    ioctl_upload = 1'b0;

    repeat (3) @(negedge clock_12);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
